// File: rtl/hazard_pkg.sv
// Shared types for the load-use hazard scoreboard: the per-stage pipeline
// record and the constants used to build and compare it.
package hazard_pkg;

  localparam int REG_AW_DEF = 4;

  localparam logic [REG_AW_DEF-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } stage_rec_t;

  localparam stage_rec_t NOP_REC = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and forwarding/stall response bundle of the hazard scoreboard.
// Handshake: no valid/ready pair; id_valid qualifies the ID fields each cycle and
// stall is the (combinational) back-pressure that makes the ID stage re-present them.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic [REG_AW-1:0] idex_dest;
  logic [REG_AW-1:0] exmem_dest;
  logic [REG_AW-1:0] memwb_dest;
  logic              exmem_reg_write;
  logic              memwb_reg_write;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_src1, id_src2, id_dest, id_reg_write, id_mem_read, flush,
    input  stall, bubble, idex_dest, exmem_dest, memwb_dest,
           exmem_reg_write, memwb_reg_write, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_dest, id_reg_write, id_mem_read, flush,
    output stall, bubble, idex_dest, exmem_dest, memwb_dest,
           exmem_reg_write, memwb_reg_write, stall_count
  );
endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record register; reset or bubble_i loads the NOP record.
import hazard_pkg::*;

module hazard_stage_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble_i,
  input  stage_rec_t rec_i,
  output stage_rec_t rec_o
);

  stage_rec_t rec_q;
  stage_rec_t rec_d;

  always_comb begin
    rec_d = rec_i;
    if (bubble_i) rec_d = NOP_REC;
  end

  always_ff @(posedge clk) begin
    if (rst) rec_q <= NOP_REC;
    else     rec_q <= rec_d;
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks ID/EX, EX/MEM and MEM/WB destination records for forwarding and
// raises a one-cycle stall when an instruction in ID needs a load still in EX.
import hazard_pkg::*;

module hazard_scoreboard #(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);

  stage_rec_t idex_rec;
  stage_rec_t exmem_rec;
  stage_rec_t memwb_rec;
  stage_rec_t id_rec;

  logic             hazard;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    id_rec           = NOP_REC;
    id_rec.valid     = 1'b1;
    id_rec.dest      = bus.id_dest;
    id_rec.reg_write = bus.id_reg_write;
    id_rec.mem_read  = bus.id_mem_read;
  end

  // Only a load still in EX cannot be forwarded; anything later is covered.
  always_comb begin
    hazard = idex_rec.valid && idex_rec.mem_read && idex_rec.reg_write &&
             (idex_rec.dest != ZERO_REG) && bus.id_valid &&
             ((idex_rec.dest == bus.id_src1) || (idex_rec.dest == bus.id_src2));
    stall  = hazard && !bus.flush;
    bubble = stall || bus.flush || !bus.id_valid;
  end

  hazard_stage_reg u_idex (
    .clk(clk), .rst(rst), .bubble_i(bubble), .rec_i(id_rec), .rec_o(idex_rec)
  );

  hazard_stage_reg u_exmem (
    .clk(clk), .rst(rst), .bubble_i(1'b0), .rec_i(idex_rec), .rec_o(exmem_rec)
  );

  hazard_stage_reg u_memwb (
    .clk(clk), .rst(rst), .bubble_i(1'b0), .rec_i(exmem_rec), .rec_o(memwb_rec)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.stall           = stall;
  assign bus.bubble          = bubble;
  assign bus.idex_dest       = idex_rec.valid  ? idex_rec.dest  : ZERO_REG;
  assign bus.exmem_dest      = exmem_rec.valid ? exmem_rec.dest : ZERO_REG;
  assign bus.memwb_dest      = memwb_rec.valid ? memwb_rec.dest : ZERO_REG;
  assign bus.exmem_reg_write = exmem_rec.valid && exmem_rec.reg_write &&
                               (exmem_rec.dest != ZERO_REG);
  assign bus.memwb_reg_write = memwb_rec.valid && memwb_rec.reg_write &&
                               (memwb_rec.dest != ZERO_REG);
  assign bus.stall_count     = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a CNT_W=16 instance and a CNT_W=2
// instance driven by the same ID-stage stimulus.
module tb_hazard_scoreboard;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];

  hazard_scoreboard_if #(.REG_AW(4), .CNT_W(16)) bus_w ();
  hazard_scoreboard_if #(.REG_AW(4), .CNT_W(2))  bus_s ();

  hazard_scoreboard #(.REG_AW(4), .CNT_W(16)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));
  hazard_scoreboard #(.REG_AW(4), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.id_valid     = bus_w.id_valid;
  assign bus_s.id_src1      = bus_w.id_src1;
  assign bus_s.id_src2      = bus_w.id_src2;
  assign bus_s.id_dest      = bus_w.id_dest;
  assign bus_s.id_reg_write = bus_w.id_reg_write;
  assign bus_s.id_mem_read  = bus_w.id_mem_read;
  assign bus_s.flush        = bus_w.flush;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic rw, input logic mr, input logic fl);
    bus_w.id_valid     = v;
    bus_w.id_src1      = s1;
    bus_w.id_src2      = s2;
    bus_w.id_dest      = d;
    bus_w.id_reg_write = rw;
    bus_w.id_mem_read  = mr;
    bus_w.flush        = fl;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // advance one edge; inputs change and outputs settle well before the next edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // issue load rd, then present a dependent op; leaves the bench in the stall cycle
  task automatic load_then_use(input logic [3:0] rd);
    set_id(1'b1, 4'd0, 4'd0, rd, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, rd, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_id(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      step();
    end
    rst = 1'b0;
    idle();
    #1;
    check("rst_idex_dest",  32'(bus_w.idex_dest), 0);
    check("rst_exmem_dest", 32'(bus_w.exmem_dest), 0);
    check("rst_memwb_dest", 32'(bus_w.memwb_dest), 0);
    check("rst_exmem_rw",   32'(bus_w.exmem_reg_write), 0);
    check("rst_memwb_rw",   32'(bus_w.memwb_reg_write), 0);
    check("rst_stall",      32'(bus_w.stall), 0);
    check("rst_count",      32'(bus_w.stall_count), 0);

    // load-use: load r5 then src1 = 5
    set_id(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
    #1 check("lu_load_no_stall", 32'(bus_w.stall), 0);
    step();
    set_id(1'b1, 4'd5, 4'd3, 4'd9, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_stall",     32'(bus_w.stall), 1);
    check("lu_bubble",    32'(bus_w.bubble), 1);
    check("lu_idex_dest", 32'(bus_w.idex_dest), 5);
    step();
    check("lu_stall_once",   32'(bus_w.stall), 0);
    check("lu_idex_nop",     32'(bus_w.idex_dest), 0);
    check("lu_exmem_dest",   32'(bus_w.exmem_dest), 5);
    check("lu_exmem_rw",     32'(bus_w.exmem_reg_write), 1);
    check("lu_count",        32'(bus_w.stall_count), 1);
    step();
    idle();
    check("lu_dep_idex",  32'(bus_w.idex_dest), 9);
    check("lu_memwb",     32'(bus_w.memwb_dest), 5);
    check("lu_memwb_rw",  32'(bus_w.memwb_reg_write), 1);
    step();

    // ALU producer followed by a src2 consumer never stalls
    set_id(1'b1, 4'd1, 4'd2, 4'd10, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 4'd4, 4'd10, 4'd11, 1'b1, 1'b0, 1'b0);
    #1 check("alu_no_stall", 32'(bus_w.stall), 0);
    step();
    idle();
    check("alu_exmem_dest", 32'(bus_w.exmem_dest), 10);
    check("alu_exmem_rw",   32'(bus_w.exmem_reg_write), 1);
    step();
    check("alu_memwb_dest", 32'(bus_w.memwb_dest), 10);
    check("alu_memwb_rw",   32'(bus_w.memwb_reg_write), 1);
    check("alu_count",      32'(bus_w.stall_count), 1);
    step();

    // load into r0 is never a hazard nor advertised
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0);
    #1 check("r0_no_stall", 32'(bus_w.stall), 0);
    step();
    idle();
    check("r0_exmem_dest", 32'(bus_w.exmem_dest), 0);
    check("r0_exmem_rw",   32'(bus_w.exmem_reg_write), 0);
    step();

    // flush wins over hazard
    set_id(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1);
    #1;
    check("fl_stall",  32'(bus_w.stall), 0);
    check("fl_bubble", 32'(bus_w.bubble), 1);
    step();
    idle();
    check("fl_idex_nop",   32'(bus_w.idex_dest), 0);
    check("fl_exmem_dest", 32'(bus_w.exmem_dest), 7);
    check("fl_count",      32'(bus_w.stall_count), 1);
    step();

    // id_valid low with matching fields
    set_id(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b0, 4'd7, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0);
    #1 check("inv_no_stall", 32'(bus_w.stall), 0);
    step();

    // both sources match: one stall cycle only
    set_id(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 4'd3, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    #1 check("both_stall", 32'(bus_w.stall), 1);
    step();
    check("both_stall_once", 32'(bus_w.stall), 0);
    check("both_count",      32'(bus_w.stall_count), 2);
    idle();
    step();

    // back-to-back ALU stream through the pipeline
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 4'd0, 4'd0, 4'(12 + i), 1'b1, 1'b0, 1'b0);
      exp_q.push_back(32'(12 + i));
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      check("stream_memwb", 32'(bus_w.memwb_dest), exp_q.pop_front());
      step();
    end

    // reset mid-stall
    load_then_use(4'd4);
    #1 check("ms_stall_before", 32'(bus_w.stall), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("ms_stall_cleared", 32'(bus_w.stall), 0);
    check("ms_count_cleared", 32'(bus_w.stall_count), 0);
    check("ms_small_cleared", 32'(bus_s.stall_count), 0);
    idle();
    step();

    // four stalls: wide counter reaches 4, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      load_then_use(4'(5 + i));
      step();
      idle();
      step();
    end
    check("sat_wide_count",  32'(bus_w.stall_count), 4);
    check("sat_small_count", 32'(bus_s.stall_count), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer side of the stage-3 forwarding path. Tracks the destination register, write-enable and load flag of every instruction in the ID/EX, EX/MEM and MEM/WB stages of the 5-stage MIPS pipeline. Drives the EX/MEM and MEM/WB destination/regWrite fields that the forwarding unit compares against. Detects load-use hazards that forwarding cannot cover, then stalls IF/ID and inserts a bubble into ID/EX.

## Interface
Parameters:
- REG_AW, 4, register-address width (16 architectural registers; register 0 hardwired zero)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_src1  in  REG_AW  ID instruction source operand 1
- id_src2  in  REG_AW  ID instruction source operand 2
- id_dest  in  REG_AW  ID instruction destination register
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch/jump taken: kill the ID instruction
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- bubble  out  1  ID/EX receives a NOP next edge (combinational)
- idex_dest, exmem_dest, memwb_dest  out  REG_AW  stage destination registers
- exmem_reg_write, memwb_reg_write  out  1  qualified write enables for forwarding
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Three stage records (IDEX, EXMEM, MEMWB). Each record is {valid, dest, reg_write, mem_read}.
- Load-use hazard = IDEX.valid & IDEX.mem_read & IDEX.reg_write & IDEX.dest != 0 & id_valid & (IDEX.dest == id_src1 | IDEX.dest == id_src2).
- stall = hazard & !flush.
- bubble = stall | flush | !id_valid.
- Each non-reset edge:
  - MEMWB <= EXMEM.
  - EXMEM <= IDEX.
  - IDEX <= bubble ? all-zero : {1, id_dest, id_reg_write, id_mem_read}.
- Qualified enables: exmem_reg_write = EXMEM.valid & EXMEM.reg_write & EXMEM.dest != 0. memwb_reg_write is formed the same way from MEMWB. A write to register 0 is never advertised.
- *_dest outputs: the raw record dest field, 0 when the record is invalid.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Non-load producers never stall; forwarding covers them.
- A load followed by a dependent instruction gives exactly one stall cycle. On the next cycle the load is in EXMEM and the bubble is in IDEX, so the hazard term is false.

## Timing
- Reset (rst=1 at an edge): all records zeroed. Next cycle: all dest = 0, all reg_write = 0, stall = 0, stall_count = 0.
- rst dominates stall and flush. A reset mid-stall clears the hazard immediately.
- stall and bubble are combinational from IDEX registers plus ID inputs, valid in the same cycle.
- Stage outputs are registered, 1 cycle per stage. An instruction accepted at edge N appears in idex_dest after N, exmem_dest after N+1, memwb_dest after N+2.
- Simultaneous flush and hazard: flush wins. stall = 0, the ID instruction is discarded, no stall count.
- Both sources match a load dest: still a single stall cycle.
- id_valid = 0 with matching fields: no stall.

## Structure
- Shared package hazard_pkg:
  - REG_AW default
  - stage-record typedef {valid, dest, reg_write, mem_read}
  - ZERO_REG constant = 0
  - the all-zero NOP record constant
- One natural sub-module: hazard_stage_reg, a single record register with synchronous reset and bubble-insert mux. Instantiate it three times.
- Hazard compare and counter live in the top level.

## Test plan
- Reset: assert rst for 2 cycles with random ID inputs. Then all dest = 0, all reg_write = 0, stall = 0, stall_count = 0.
- Load-use: load r5 (dest 5, mem_read 1) followed by an instruction with src1 = 5.
  - Expect stall = 1 for exactly one cycle and bubble in IDEX.
  - Then exmem_dest = 5, exmem_reg_write = 1 on the following cycle.
  - stall_count = 1.
- ALU dependency: add r10 followed by an instruction with src2 = 10.
  - stall stays 0.
  - exmem_dest = 10, exmem_reg_write = 1 one cycle later.
  - memwb_dest = 10, memwb_reg_write = 1 two cycles later.
- Register 0: load r0 followed by an instruction with src1 = 0.
  - No stall.
  - exmem_reg_write = 0 while exmem_dest = 0.
- Flush vs hazard: load r7, then an instruction with src1 = 7 and flush = 1 in the same cycle.
  - stall = 0, IDEX becomes a NOP, stall_count unchanged.
- Reset mid-stall and counter saturation:
  - rst during a stall cycle clears stall on the next cycle.
  - With CNT_W = 2, four stalls leave stall_count = 3.
